rr_arbiter_8_enc: RTL
=====================

Name: rr_arbiter_8_enc

Overview:
- Round-robin arbiter that shares one resource between 8 requesters.
- Produces a registered one-hot grant and its 3-bit binary index, the same one-hot-to-index mapping as the team's 8:3 encoder.
- Sits in front of any shared datapath (bus, ALU, memory port) and sequences ownership one requester at a time.

Parameters:
- HOLD_MAX, 16, maximum grant tenure in cycles before forced release (used only with ARB_TIMEOUT_EN); legal range 1..255.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- en  input  1  arbiter enable; 0 blocks new grants, does not revoke a current grant
- req  input  8  request vector, bit i = requester i
- done  input  1  owner signals end of use; sampled only in GRANT
- gnt  output  8  registered one-hot grant, 0 when idle
- gnt_idx  output  3  binary index of granted bit, 3'd0 when idle
- gnt_valid  output  1  1 while a grant is held
- timeout  output  1  one-cycle pulse on forced release; constant 0 without ARB_TIMEOUT_EN

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, gnt=8'h00, gnt_idx=3'd0, gnt_valid=0, timeout=0.
  - Priority pointer ptr=3'd0; tenure counter=0.
  - Outputs take reset values immediately, regardless of clk.
- States: IDLE, GRANT. All outputs are registered.
- IDLE, transition to GRANT:
  - Condition: en=1 and req!=0.
  - Winner w = first set bit of req scanning ptr, ptr+1, ... ptr+7, with wrap from 7 to 0.
  - Next edge: gnt=1<<w, gnt_idx=w, gnt_valid=1.
  - Latency: req asserted in cycle N gives a grant visible after edge N+1.
- IDLE otherwise: stays in IDLE; all outputs 0.
- GRANT, release condition (evaluated each cycle):
  - done=1, or
  - req[gnt_idx]=0 (requester withdrew), or
  - timeout condition (feature only).
- On release:
  - Next edge: state=IDLE, gnt=0, gnt_idx=0, gnt_valid=0.
  - ptr=gnt_idx+1 with 3-bit wrap, so 7 wraps to 0.
- Bubble: there is always exactly one IDLE cycle between consecutive grants, even with requests pending.
- GRANT hold: otherwise stays in GRANT; gnt is stable. Changes to other req bits are ignored.
- en=0 during GRANT: no effect; the grant is held until a release condition.
- Simultaneous done and withdrawal: a single release; ptr advances once.
- done in IDLE: ignored.
- Invariants:
  - gnt is always zero or one-hot.
  - gnt_idx equals the encoded gnt, with gnt=0 mapping to 3'd0.
- Fairness: after requester i is served, requester i has the lowest priority for the next arbitration. No starvation while all requesters eventually release.
- Reset mid-GRANT: grant drops asynchronously and ptr returns to 0.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - 8-bit tenure counter clears on entry to GRANT and increments each GRANT cycle.
  - When counter==HOLD_MAX-1 with no other release, the arbiter force-releases at the next edge.
  - timeout=1 for exactly that one cycle, coincident with gnt_valid falling; ptr advances as in a normal release.
  - If done or withdrawal occurs in the same cycle, release is normal and timeout stays 0.
- Not defined:
  - No counter logic.
  - timeout tied to 0.
  - Grants are held indefinitely until done or withdrawal.

Test Plan:
- Reset, then en=1, req=8'h00 for 5 cycles -> gnt=8'h00, gnt_idx=0, gnt_valid=0 throughout; assert rst_n=0 mid-cycle -> outputs 0 without a clock edge.
- req=8'h24 from reset (ptr=0) -> gnt=8'h04, gnt_idx=2; done pulse -> IDLE for one cycle; then gnt=8'h20, gnt_idx=5.
- req=8'hFF held, done pulsed each GRANT cycle -> gnt_idx sequence 0,1,2,3,4,5,6,7,0 (wrap), each grant separated by one idle cycle.
- Granted to 3 with req=8'h88; drop req[3] while done=0 -> release on next edge; next grant is gnt_idx=7.
- en=0 with req=8'h01 -> no grant; en=1 -> grant 0; en=0 during GRANT -> grant held until done.
- ARB_TIMEOUT_EN defined, HOLD_MAX=4, req=8'h02 held, done=0 -> gnt_valid high exactly 4 cycles, timeout pulses 1 cycle at release; then ptr=2 and 1 is re-granted after one idle cycle.

Source files
------------

// File: rtl/rr_arbiter_8_enc_if.sv
// Request/grant bundle between requesters (master) and the 8-way round-robin arbiter (slave).
interface rr_arbiter_8_enc_if;
  logic       en;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  modport master (
    output en, req, done,
    input  gnt, gnt_idx, gnt_valid, timeout
  );

  modport slave (
    input  en, req, done,
    output gnt, gnt_idx, gnt_valid, timeout
  );
endinterface

// File: rtl/rr_arbiter_8_enc.sv
// 8-way round-robin arbiter with registered one-hot grant and encoded index.
// Optional forced release after HOLD_MAX cycles of tenure when ARB_TIMEOUT_EN is defined.
module rr_arbiter_8_enc #(
  parameter int HOLD_MAX = 16
) (
  input logic              clk,
  input logic              rst_n,
  rr_arbiter_8_enc_if.slave bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state;
  logic [7:0] gnt_r;
  logic [2:0] idx_r;
  logic [2:0] ptr;
  logic [2:0] winner;
  logic       winner_found;
  logic [2:0] scan_idx;
  logic       release_normal;
  logic       release_any;

  if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_bad_hold_max
    $error("HOLD_MAX must be in 1..255");
  end

  // Rotating priority scan: the pointer position is checked first, wrapping 7 -> 0.
  always_comb begin
    winner       = 3'd0;
    winner_found = 1'b0;
    scan_idx     = 3'd0;
    for (int k = 0; k < 8; k++) begin
      scan_idx = ptr + k[2:0];
      if (!winner_found && bus.req[scan_idx]) begin
        winner       = scan_idx;
        winner_found = 1'b1;
      end
    end
  end

  assign release_normal = bus.done || !bus.req[idx_r];

`ifdef ARB_TIMEOUT_EN
  logic [7:0] tenure;
  logic       timeout_r;
  logic       force_release;

  assign force_release = (tenure == 8'(HOLD_MAX - 1)) && !release_normal;
  assign release_any   = release_normal || force_release;
  assign bus.timeout   = timeout_r;
`else
  assign release_any   = release_normal;
  assign bus.timeout   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      gnt_r <= 8'h00;
      idx_r <= 3'd0;
      ptr   <= 3'd0;
`ifdef ARB_TIMEOUT_EN
      tenure    <= 8'd0;
      timeout_r <= 1'b0;
`endif
    end else begin
`ifdef ARB_TIMEOUT_EN
      timeout_r <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (bus.en && winner_found) begin
            state <= GRANT;
            gnt_r <= 8'b1 << winner;
            idx_r <= winner;
`ifdef ARB_TIMEOUT_EN
            tenure <= 8'd0;
`endif
          end
        end
        GRANT: begin
          // The served requester drops to lowest priority for the next scan.
          if (release_any) begin
            state <= IDLE;
            gnt_r <= 8'h00;
            idx_r <= 3'd0;
            ptr   <= idx_r + 3'd1;
`ifdef ARB_TIMEOUT_EN
            timeout_r <= force_release;
`endif
          end
`ifdef ARB_TIMEOUT_EN
          else begin
            tenure <= tenure + 8'd1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt       = gnt_r;
  assign bus.gnt_idx   = idx_r;
  assign bus.gnt_valid = (state == GRANT);

endmodule
